// File: rtl/scan_pkg.sv
// Shared state type and sizing constants for the snake-order scan controller.
package scan_pkg;

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned WSEL_W     = 2;
  localparam int unsigned W_COLS_DEF = 4;
  localparam int unsigned W_ROWS_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_PAIR,
    S_SNAKE,
    S_FIN
  } state_e;

endpackage

// File: rtl/serp_cnt.sv
// Bidirectional column counter for the serpentine scan. Terminal count is
// decoded from the current value, so a down-count never wraps below zero.
module serp_cnt
  import scan_pkg::*;
#(
  parameter int unsigned MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // dir_i=1 counts toward 0, dir_i=0 counts toward MAX
  assign tc_c_o = dir_i ? (cnt_q == '0) : (cnt_q == CNT_W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_c_o) begin
      cnt_d = dir_i ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/snake_scan_ctrl.sv
// Feature-map scan sequencer: optional weight preload, two-row pair scan, then
// serpentine rows. Weight preload is built only when SCAN_WEIGHT_PRELOAD_EN is defined.
module snake_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned ROW    = 256,
  parameter int unsigned COL    = 256,
  parameter int unsigned W_COLS = W_COLS_DEF,
  parameter int unsigned W_ROWS = W_ROWS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [CNT_W-1:0]  addr_row,
  output logic [CNT_W-1:0]  addr_col,
  output logic              w_valid,
  output logic [WSEL_W-1:0] w_fcol,
  output logic [WSEL_W-1:0] w_prow,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [WSEL_W-1:0] wf_q, wf_d, wp_q, wp_d;
  logic              addr_valid_q, busy_q, done_q;
  logic              hs_c, scan_c, col_en_c, col_dir_c, col_tc_c;
  logic [CNT_W-1:0]  col_cnt;

  // Column moves on row 1 of a pair, and on every snake beat; even snake rows run downward
  assign hs_c      = addr_valid_q & addr_ready;
  assign col_en_c  = hs_c & ((state_q == S_SNAKE) | row_q[0]);
  assign col_dir_c = (state_q == S_SNAKE) & ~row_q[0];
  assign scan_c    = (state_d == S_PAIR) || (state_d == S_SNAKE);

  serp_cnt #(
    .MAX (COL - 1)
  ) u_col (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (~scan_c),
    .en_i   (col_en_c),
    .dir_i  (col_dir_c),
    .cnt_o  (col_cnt),
    .tc_c_o (col_tc_c)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wf_d    = wf_q;
    wp_d    = wp_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SCAN_WEIGHT_PRELOAD_EN
          state_d = S_WLOAD;
`else
          state_d = S_PAIR;
`endif
        end
      end
      S_WLOAD: begin
        if (wp_q == WSEL_W'(W_ROWS - 1)) begin
          wp_d = '0;
          if (wf_q == WSEL_W'(W_COLS - 1)) state_d = S_PAIR;
          else                             wf_d = wf_q + WSEL_W'(1);
        end else begin
          wp_d = wp_q + WSEL_W'(1);
        end
      end
      S_PAIR: begin
        if (hs_c) begin
          if (!row_q[0]) begin
            row_d = CNT_W'(1);
          end else if (col_tc_c) begin
            if (ROW > 2) begin
              state_d = S_SNAKE;
              row_d   = CNT_W'(2);
            end else begin
              state_d = S_FIN;
            end
          end else begin
            row_d = '0;
          end
        end
      end
      S_SNAKE: begin
        // Row turn keeps the column: each row's end column is the next row's start
        if (hs_c && col_tc_c) begin
          if (row_q == CNT_W'(ROW - 1)) state_d = S_FIN;
          else                          row_d   = row_q + CNT_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;
    if (!scan_c) row_d = '0;
    if (state_d != S_WLOAD) begin
      wf_d = '0;
      wp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      wf_q         <= '0;
      wp_q         <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      wf_q         <= wf_d;
      wp_q         <= wp_d;
      addr_valid_q <= scan_c;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_FIN);
    end
  end

  assign addr_valid = addr_valid_q;
  assign addr_row   = row_q;
  assign addr_col   = col_cnt;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SCAN_WEIGHT_PRELOAD_EN
  logic w_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_valid_q <= 1'b0;
    else        w_valid_q <= (state_d == S_WLOAD);
  end

  assign w_valid = w_valid_q;
  assign w_fcol  = wf_q;
  assign w_prow  = wp_q;
`else
  assign w_valid = 1'b0;
  assign w_fcol  = '0;
  assign w_prow  = '0;
`endif

endmodule

// File: doc/snake_scan_ctrl.md
SNAKE_SCAN_CTRL -- requirements
Module: snake_scan_ctrl

Interface
REQ-001 Parameter ROW, default 256: feature-map rows; legal range 2..1023.
REQ-002 Parameter COL, default 256: feature-map columns; legal range 1..1023.
REQ-003 Parameter W_COLS, default 4: weight filter columns.
REQ-004 Parameter W_ROWS, default 3: PE-array rows per filter column.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-008 abort  input  1  synchronous clear back to IDLE.
REQ-009 addr_ready  input  1  downstream (DRAM/feeder) accepts the current address.
REQ-010 addr_valid  output  1  addr_row/addr_col hold a valid feature-map coordinate.
REQ-011 addr_row  output  10  feature-map row index.
REQ-012 addr_col  output  10  feature-map column index.
REQ-013 w_valid  output  1  weight-select strobe, one beat per cycle.
REQ-014 w_fcol  output  2  filter column of the current weight beat.
REQ-015 w_prow  output  2  PE-array row of the current weight beat.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at scan completion.

Function
REQ-018 FSM states: IDLE, WLOAD, PAIR, SNAKE, FIN.
REQ-019 IDLE->WLOAD on start; start SHALL be ignored in every other state.
REQ-020 WLOAD: exactly W_COLS*W_ROWS consecutive cycles with w_valid=1; order is w_fcol outer 0..W_COLS-1, w_prow inner 0..W_ROWS-1; no handshake; then ->PAIR.
REQ-021 PAIR: col outer 0..COL-1, row inner 0..1; emits (0,0),(1,0),(0,1),(1,1)... up to (1,COL-1); then ->SNAKE if ROW>2, else ->FIN.
REQ-022 SNAKE: rows 2..ROW-1; even row scans col COL-1 down to 0; odd row scans col 0 up to COL-1; after (ROW-1, last col) ->FIN.
REQ-023 Address handshake: addr_valid=1 throughout PAIR/SNAKE; address advances only on the cycle where addr_valid & addr_ready; address SHALL stay stable while addr_ready=0.
REQ-024 Total accepted address beats per scan SHALL equal ROW*COL, each coordinate exactly once.
REQ-025 The first PAIR address SHALL be presented the cycle after the last WLOAD beat; zero bubbles between beats when addr_ready is held high.
REQ-026 FIN: done=1 for exactly one cycle, then ->IDLE; busy=0 in that following IDLE cycle.
REQ-027 abort=1 in any state: next cycle IDLE, all outputs at reset values, no done pulse; abort takes priority over start and over a simultaneous handshake.
REQ-028 Row/col counters are unsigned 10-bit; down-count from 0 SHALL never wrap (the transition is decoded before decrement).
REQ-029 COL=1: every row emits the single column 0; direction is irrelevant, no stall.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, all counters to 0, and addr_valid, w_valid, busy, done, addr_row, addr_col, w_fcol, w_prow to 0.
REQ-031 Reset asserted mid-scan SHALL discard the scan; a new start after release begins again at WLOAD.

Configuration
REQ-032 Macro SCAN_WEIGHT_PRELOAD_EN: when defined, WLOAD runs as in REQ-020; when undefined, IDLE->PAIR directly on start, w_valid is tied 0 and w_fcol/w_prow are tied 0.

Structure
REQ-033 Package scan_pkg SHALL hold the FSM state typedef, the counter width constant (10), and the W_COLS/W_ROWS defaults.
REQ-034 One sub-module, serp_cnt, SHALL implement the bidirectional column counter with terminal-count detect; the FSM and row counter stay in snake_scan_ctrl.

Verification
REQ-035 ROW=4, COL=3, addr_ready=1, start pulse -> 12 w_valid beats (0,0),(0,1),(0,2),(1,0)..(3,2), then addresses (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(2,2),(2,1),(2,0),(3,0),(3,1),(3,2), then a single done pulse.
REQ-036 Same config, addr_ready toggling 1,0,1,0 -> same 12-address sequence; each address held for exactly its stall cycles; done only after the 12th accepted beat.
REQ-037 abort asserted on the 5th accepted address -> next cycle busy=0, addr_valid=0, no done; a later start restarts at WLOAD beat (0,0).
REQ-038 rst_n pulsed low mid-SNAKE -> outputs 0 asynchronously, before the next clock edge; start pulsed while busy is ignored.
REQ-039 ROW=2, COL=1 with SCAN_WEIGHT_PRELOAD_EN undefined -> addresses (0,0),(1,0), then done; w_valid never asserted.
REQ-040 ROW=256, COL=256 -> 65536 accepted beats with no duplicate coordinate; last address (255,255); done count 1.
